// File: rtl/imm_encoder.sv
// Immediate-field encoder with a one-deep valid/ready output register.
// Define IMM_ENCODER_RANGE_CHECK_EN to build overflow detection (Ovf, ErrCnt).
module imm_encoder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [1:0]  Fmt,
  input  logic [31:0] Template,
  input  logic [63:0] Imm,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Instr,
  output logic        Ovf,
  output logic [7:0]  ErrCnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_d, state_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] instr_new;
  logic        accept;

  assign OutValid = (state_q == FULL);
  assign InReady  = !OutValid || OutReady;
  assign accept   = InValid && InReady;
  assign Instr    = instr_q;

  // Field bits are overwritten, so template contents inside the field never leak through.
  always_comb begin
    instr_new = Template;
    case (Fmt)
      2'd0:    instr_new[21:10] = Imm[11:0];
      2'd1:    instr_new[20:12] = Imm[8:0];
      2'd2:    instr_new[23:5]  = Imm[18:0];
      default: instr_new[25:0]  = Imm[25:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept) state_d = FULL;
        else if (OutReady) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) instr_d = instr_new;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic       ovf_new, ovf_d, ovf_q;
  logic [7:0] err_cnt_d, err_cnt_q;

  // Representable iff every bit from the field's sign bit upward is identical.
  always_comb begin
    case (Fmt)
      2'd0:    ovf_new = !((&Imm[63:11]) || !(|Imm[63:11]));
      2'd1:    ovf_new = !((&Imm[63:8])  || !(|Imm[63:8]));
      2'd2:    ovf_new = !((&Imm[63:18]) || !(|Imm[63:18]));
      default: ovf_new = !((&Imm[63:25]) || !(|Imm[63:25]));
    endcase
  end

  always_comb begin
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      ovf_d = ovf_new;
      if (ovf_new && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Ovf    = ovf_q;
  assign ErrCnt = err_cnt_q;
`else
  logic unused_imm_hi;

  assign unused_imm_hi = ^Imm[63:26];
  assign Ovf           = 1'b0;
  assign ErrCnt        = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized + directed bench for imm_encoder against a behavioural model.
// Expectations for Ovf/ErrCnt follow IMM_ENCODER_RANGE_CHECK_EN.
module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, InValid, OutReady;
  logic [1:0]  Fmt;
  logic [31:0] Template;
  logic [63:0] Imm;
  logic        InReady, OutValid, Ovf;
  logic [31:0] Instr;
  logic [7:0]  ErrCnt;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // behavioural model state
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  bit          m_ovf = 1'b0;
  int          m_cnt = 0;

  imm_encoder dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Fmt(Fmt), .Template(Template), .Imm(Imm), .OutValid(OutValid),
    .OutReady(OutReady), .Instr(Instr), .Ovf(Ovf), .ErrCnt(ErrCnt)
  );

  always #5 Clk = ~Clk;

  function automatic int fld_w(logic [1:0] f);
    case (f)
      2'd0: return 12;
      2'd1: return 9;
      2'd2: return 19;
      default: return 26;
    endcase
  endfunction

  function automatic int fld_lsb(logic [1:0] f);
    case (f)
      2'd0: return 10;
      2'd1: return 12;
      2'd2: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] encode(logic [1:0] f, logic [31:0] t, logic [63:0] v);
    logic [31:0] r = t;
    for (int i = 0; i < fld_w(f); i++) r[fld_lsb(f) + i] = v[i];
    return r;
  endfunction

  function automatic bit overflows(logic [1:0] f, logic [63:0] v);
    longint sv = v;
    longint ext;
    int sh = 64 - fld_w(f);
    ext = (sv <<< sh) >>> sh;
    return ext != sv;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    bit acc;
    if (Reset) begin
      m_valid = 1'b0; m_instr = '0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      acc = InValid && (!m_valid || OutReady);
      if (acc) begin
        m_instr = encode(Fmt, Template, Imm);
        m_ovf   = RC && overflows(Fmt, Imm);
        if (m_ovf && m_cnt < 255) m_cnt++;
        m_valid = 1'b1;
      end else if (m_valid && OutReady) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("OutValid", 64'(OutValid), 64'(m_valid));
      chk("InReady", 64'(InReady), 64'(!m_valid || OutReady));
      chk("Instr", 64'(Instr), 64'(m_instr));
      chk("Ovf", 64'(Ovf), 64'(m_ovf));
      chk("ErrCnt", 64'(ErrCnt), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic beat(bit v, bit r, logic [1:0] f, logic [31:0] t, logic [63:0] i);
    InValid = v; OutReady = r; Fmt = f; Template = t; Imm = i;
  endtask

  function automatic logic [63:0] pick_imm(logic [1:0] f);
    longint half = longint'(1) <<< (fld_w(f) - 1);
    case ($urandom_range(0, 7))
      0: return 64'(half - 1);
      1: return 64'(half);
      2: return 64'(-half);
      3: return 64'(-half - 1);
      4: return {$urandom, $urandom};
      5: return 64'(longint'($urandom_range(0, 2000)) - 1000);
      default: return 64'($urandom_range(0, 32'(half) - 1));
    endcase
  endfunction

  initial begin
    beat(1'b0, 1'b0, 2'd0, '0, '0);
    Reset = 1'b1;
    tick();
    started = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    chk("lit_inready_after_reset", 64'(InReady), 64'd1);
    chk("lit_outvalid_after_reset", 64'(OutValid), 64'd0);

    beat(1'b1, 1'b1, 2'd0, 32'h9100002C, 64'h400);
    tick();
    chk("lit_i_pos", 64'(Instr), 64'h9110002C);
    chk("lit_i_pos_ovf", 64'(Ovf), 64'd0);
    chk("lit_i_pos_valid", 64'(OutValid), 64'd1);

    beat(1'b1, 1'b1, 2'd0, 32'h9200001E, 64'hFFFFFFFFFFFFFE00);
    tick();
    chk("lit_i_neg", 64'(Instr), 64'h9238001E);
    chk("lit_i_neg_ovf", 64'(Ovf), 64'd0);

    beat(1'b1, 1'b1, 2'd1, 32'hF8400108, 64'hFFFFFFFFFFFFFFFE);
    tick();
    chk("lit_d_neg", 64'(Instr), 64'hF85FE108);
    chk("lit_d_neg_cnt", 64'(ErrCnt), 64'd0);
    beat(1'b1, 1'b1, 2'd1, 32'hF8400108, 64'h100);
    tick();
    chk("lit_d_ovf_instr", 64'(Instr), 64'hF8500108);
    chk("lit_d_ovf", 64'(Ovf), 64'(RC));
    chk("lit_d_ovf_cnt", 64'(ErrCnt), RC ? 64'd1 : 64'd0);

    // stall: held beat must survive three back-pressured cycles
    beat(1'b1, 1'b1, 2'd3, 32'h0, 64'h123);
    tick();
    beat(1'b1, 1'b0, 2'd3, 32'hFC000000, 64'h5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_stall_inready", 64'(InReady), 64'd0);
      chk("lit_stall_instr", 64'(Instr), 64'h00000123);
      chk("lit_stall_valid", 64'(OutValid), 64'd1);
    end
    OutReady = 1'b1;
    tick();
    chk("lit_release_instr", 64'(Instr), 64'hFC000005);
    chk("lit_release_valid", 64'(OutValid), 64'd1);

    beat(1'b1, 1'b1, 2'd0, 32'h0, 64'h800);
    for (int k = 0; k < 260; k++) tick();
    chk("lit_cnt_saturate", 64'(ErrCnt), RC ? 64'd255 : 64'd0);
    Reset = 1'b1;
    tick();
    chk("lit_reset_valid", 64'(OutValid), 64'd0);
    chk("lit_reset_instr", 64'(Instr), 64'd0);
    chk("lit_reset_cnt", 64'(ErrCnt), 64'd0);
    Reset = 1'b0;
    beat(1'b0, 1'b1, 2'd0, '0, '0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [1:0] f;
      f = 2'($urandom_range(0, 3));
      Reset = ($urandom_range(0, 299) == 0);
      beat($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, f, $urandom, pick_imm(f));
      tick();
    end
    Reset = 1'b0;
    beat(1'b0, 1'b1, 2'd0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
